timer_core: RTL

Counting core that produces the 14-bit binary value (0..9999) consumed by the 4-digit 7-segment display controller.
- Provides run/pause control, clear, and a manual adjust mode.
- Counting is driven by an internal prescaled tick.
- `value` connects directly to the display controller's `value` input. No BCD conversion happens here.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_core_if.sv | 45 ++++
 rtl/tick_gen.sv | 46 ++++
 rtl/timer_core.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the timer_core counting block.
//   timer_state_e : controller states (IDLE, RUN, PAUSE, ADJUST)
//   VALUE_W       : width of the displayed count
//   STEP_FINE     : ADJUST step with adj_sel = 0
//   STEP_COARSE   : ADJUST step with adj_sel = 1
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int VALUE_W     = 14;
   localparam int STEP_FINE   = 1;
   localparam int STEP_COARSE = 100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSE  = 2'd2,
      ADJUST = 2'd3
   } timer_state_e;

endpackage

// File: rtl/timer_core_if.sv
// ---------------------------------------------------------------------------
// timer_core_if
// Control and result signals of timer_core.
//   start_stop : pulse, toggles RUN/PAUSE
//   clear      : pulse, forces count to 0 and state to IDLE
//   adj        : level, holds the block in ADJUST
//   adj_sel    : ADJUST step select (0 = fine, 1 = coarse)
//   down       : level, count direction (only with TIMER_CORE_COUNTDOWN_EN)
//   value      : current count
//   running    : high in RUN
//   wrap       : one-cycle pulse on rollover (or countdown done)
// Modports: master drives the controls, slave is the timer itself.
// Optional macro: TIMER_CORE_COUNTDOWN_EN adds the down signal.
// ---------------------------------------------------------------------------
interface timer_core_if;
   import timer_pkg::*;

   logic               start_stop;
   logic               clear;
   logic               adj;
   logic               adj_sel;
`ifdef TIMER_CORE_COUNTDOWN_EN
   logic               down;
`endif
   logic [VALUE_W-1:0] value;
   logic               running;
   logic               wrap;

   modport master (
`ifdef TIMER_CORE_COUNTDOWN_EN
      output down,
`endif
      output start_stop, clear, adj, adj_sel,
      input  value, running, wrap
   );

   modport slave (
`ifdef TIMER_CORE_COUNTDOWN_EN
      input  down,
`endif
      input  start_stop, clear, adj, adj_sel,
      output value, running, wrap
   );

endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every DIV enabled cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset (restarts the period)
//   en   : count enable; the count is held while low
//   clr  : restart the period (same effect as rst)
//   tick : high for the last enabled cycle of each period
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Down-counter: terminal count 0 marks the end of a period.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = RELOAD;
      end else if (en) begin
         cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
      end
   end

   assign tick = en && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_core.sv
// ---------------------------------------------------------------------------
// timer_core
// Binary count (0..MAX_VALUE) for the 4-digit display, with run/pause,
// clear and a manual adjust mode stepping +1 or +100.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : timer_core_if.slave (controls in, value/running/wrap out)
// Optional macro: TIMER_CORE_COUNTDOWN_EN enables bus.down (count down;
// RUN stops in PAUSE on reaching 0 with a wrap pulse).
//
// state  | meaning
// IDLE   | after reset/clear, count held, waiting for start
// RUN    | counting on run_tick
// PAUSE  | count and run prescaler phase held
// ADJUST | stepping on adj_tick while adj is high
// ---------------------------------------------------------------------------
module timer_core
   import timer_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 1,
   parameter int ADJ_HZ    = 4,
   parameter int MAX_VALUE = 9999
) (
   input  logic        clk,
   input  logic        rst,
   timer_core_if.slave bus
);

   localparam int RUN_DIV = CLK_HZ / TICK_HZ;
   localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;

   localparam logic [VALUE_W:0] MAX_W    = (VALUE_W+1)'(MAX_VALUE);
   localparam logic [VALUE_W:0] MOD_W    = (VALUE_W+1)'(MAX_VALUE + 1);
   localparam logic [VALUE_W:0] FINE_W   = (VALUE_W+1)'(STEP_FINE);
   localparam logic [VALUE_W:0] COARSE_W = (VALUE_W+1)'(STEP_COARSE);

   timer_state_e       state_q, state_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               running_q, running_d;
   logic               wrap_q, wrap_d;

   logic               run_tick, adj_tick;
   logic               run_clr, adj_clr;
   logic               down_en;
   logic               cd_done;
   logic [VALUE_W:0]   step_amt;
   logic [VALUE_W:0]   sum;

`ifdef TIMER_CORE_COUNTDOWN_EN
   assign down_en = bus.down;
`else
   assign down_en = 1'b0;
`endif

   // Run period restarts only from IDLE so PAUSE resumes mid-period;
   // the adjust period restarts on every entry so the first step is a
   // full period after adj rises.
   assign run_clr = bus.clear || ((state_q == IDLE) && (state_d == RUN));
   assign adj_clr = bus.clear || ((state_q != ADJUST) && (state_d == ADJUST));

   tick_gen #(.DIV(RUN_DIV)) u_run_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == RUN),
      .clr  (run_clr),
      .tick (run_tick)
   );

   tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ADJUST),
      .clr  (adj_clr),
      .tick (adj_tick)
   );

   // Countdown in RUN finishes on the tick that lands on (or sits at) 0.
   assign cd_done = down_en && (state_q == RUN) && run_tick &&
                    (value_q <= VALUE_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         value_q   <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   // Next state: clear > adj > start_stop
   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = IDLE;
      end else if (bus.adj) begin
         state_d = ADJUST;
      end else begin
         case (state_q)
            IDLE:    if (bus.start_stop) state_d = RUN;
            RUN:     if (bus.start_stop || cd_done) state_d = PAUSE;
            PAUSE:   if (bus.start_stop) state_d = RUN;
            ADJUST:  state_d = PAUSE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      value_d   = value_q;
      wrap_d    = 1'b0;
      running_d = (state_d == RUN);
      step_amt  = ((state_q == ADJUST) && bus.adj_sel) ? COARSE_W : FINE_W;
      sum       = {1'b0, value_q} + step_amt;

      if (bus.clear) begin
         value_d = '0;
      end else if (((state_q == RUN) && run_tick) ||
                   ((state_q == ADJUST) && adj_tick)) begin
         if (down_en) begin
            if (state_q == RUN) begin
               // Saturate at 0; wrap doubles as the "done" pulse.
               if (value_q != '0) begin
                  value_d = value_q - VALUE_W'(1);
               end
               wrap_d = (value_q == VALUE_W'(1));
            end else if ({1'b0, value_q} < step_amt) begin
               value_d = VALUE_W'({1'b0, value_q} + MOD_W - step_amt);
               wrap_d  = 1'b1;
            end else begin
               value_d = VALUE_W'({1'b0, value_q} - step_amt);
            end
         end else if (sum > MAX_W) begin
            value_d = VALUE_W'(sum - MOD_W);
            wrap_d  = 1'b1;
         end else begin
            value_d = sum[VALUE_W-1:0];
         end
      end
   end

   assign bus.value   = value_q;
   assign bus.running = running_q;
   assign bus.wrap    = wrap_q;

endmodule
